alsu_pipe: RTL and testbench

Parametrised successor of the team's 3-bit ALSU. Signed operand width is configurable, and the output is widened to 2×WIDTH so products and sums never truncate. Transactions are accepted through a valid/ready handshake. Multiply is a multi-cycle shift-add engine, so the block suits datapaths where WIDTH is too large for a single-cycle multiplier.

---
 rtl/alsu_pipe.sv | 130 +++++++++++++
 tb/tb_alsu_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alsu_pipe.sv
// alsu_pipe: handshaked ALSU with widened signed output and a multi-cycle shift-add multiplier.
module alsu_pipe #(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     A,
  input  logic signed [WIDTH-1:0]     B,
  input  logic [2:0]                  opcode,
  input  logic                        cin,
  input  logic                        serial_in,
  input  logic                        direction,
  input  logic                        red_op_A,
  input  logic                        red_op_B,
  input  logic                        bypass_A,
  input  logic                        bypass_B,
  output logic signed [2*WIDTH-1:0]   out,
  output logic                        out_valid,
  output logic [LED_WIDTH-1:0]        leds
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_pri, w_red, w_sel, w_mag_a, w_mag_b, r_mplier;
  logic [2:0] r_op;
  logic r_cin, r_si, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b;
  logic r_ready, r_out_valid;
  logic [W2-1:0] r_out, w_res, r_acc, r_mcand, w_acc_nxt;
  logic [LED_WIDTH-1:0] r_leds;
  logic [CW-1:0] r_cnt;
  logic w_cin, w_invalid, w_go_mul, w_mul_last, w_done, w_accept;
  function automatic logic [W2-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction
  assign w_accept   = in_valid && r_ready;
  assign w_invalid  = ((r_red_a || r_red_b) && r_op >= 3'd2) || r_op >= 3'd6;
  assign w_pri      = (INPUT_PRIORITY == "A") ? r_a : r_b;
  assign w_red      = (r_red_a && r_red_b) ? w_pri : (r_red_a ? r_a : r_b);
  assign w_sel      = (r_byp_a && r_byp_b) ? w_pri : (r_byp_a ? r_a : r_b);
  assign w_cin      = (FULL_ADDER == "ON") ? r_cin : 1'b0;
  assign w_go_mul   = !w_invalid && !(r_byp_a || r_byp_b) && r_op == 3'd3;
  assign w_mag_a    = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
  assign w_mag_b    = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = r_state == MUL && r_cnt == CW'(WIDTH - 1);
  assign w_done     = (r_state == EXEC && !w_go_mul) || w_mul_last;
  always_comb begin
    w_res = r_out;
    if (r_byp_a || r_byp_b) w_res = sext(w_sel);
    else case (r_op)
      3'd0: w_res = (r_red_a || r_red_b) ? W2'(|w_red) : sext(r_a | r_b);
      3'd1: w_res = (r_red_a || r_red_b) ? W2'(^w_red) : sext(r_a ^ r_b);
      3'd2: w_res = sext(r_a) + sext(r_b) + W2'(w_cin);
      3'd4: w_res = r_dir ? {r_out[W2-2:0], r_si} : {r_si, r_out[W2-1:1]};
      3'd5: w_res = r_dir ? {r_out[W2-2:0], r_out[W2-1]} : {r_out[0], r_out[W2-1:1]};
      default: w_res = r_out;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? EXEC : IDLE;
      EXEC:    w_next = w_go_mul ? MUL : IDLE;
      MUL:     w_next = w_mul_last ? IDLE : MUL;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_out <= '0;
      r_leds <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      {r_cin, r_si, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b} <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == IDLE;
      r_out_valid <= w_done;
      if (w_accept) begin
        r_a <= A;
        r_b <= B;
        r_op <= opcode;
        {r_cin, r_si, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b} <=
          {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};
      end
      if (r_state == EXEC) begin
        if (w_invalid) begin
          r_out <= '0;
          r_leds <= ~r_leds;
        end else if (w_go_mul) begin
          r_acc <= '0;
          r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
          r_mplier <= w_mag_b;
          r_cnt <= '0;
        end else begin
          r_out <= w_res;
          r_leds <= '0;
        end
      end
      if (r_state == MUL) begin
        r_acc <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt <= r_cnt + CW'(1);
        if (w_mul_last) begin
          r_out <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_acc_nxt : w_acc_nxt;
          r_leds <= '0;
        end
      end
    end
  end
  assign in_ready  = r_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign leds      = r_leds;
endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed self-checking bench for alsu_pipe at WIDTH=3.
module tb_alsu_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [2:0] a = 0, b = 0, opcode = 0;
  logic cin = 0, serial_in = 0, direction = 0, red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
  logic in_ready, out_valid;
  logic signed [5:0] out;
  logic [15:0] leds;
  int checks = 0, passes = 0;
  alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .out_valid(out_valid), .leds(leds)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [2:0] op, input logic [2:0] ia, input logic [2:0] ib,
                       input logic c = 0, input logic si = 0, input logic dir = 0,
                       input logic ra = 0, input logic rb = 0, input logic ba = 0, input logic bb = 0);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL issue_ready in_ready=%b expected=1", in_ready);
    end
    opcode = op; a = ia; b = ib; cin = c; serial_in = si; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 20);
  endtask
  task automatic test_reset();
    #12;
    checks++; if ({out, out_valid, leds, in_ready} !== 24'd0) $display("FAIL reset_state out=%b ov=%b leds=%h rdy=%b expected all 0", out, out_valid, leds, in_ready); else passes++;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready in_ready=%b expected=1", in_ready); else passes++;
  endtask
  task automatic test_add();
    int lat;
    issue(3'd2, 3'd3, 3'd3, 1);
    wait_done(lat);
    checks++; if (out !== 6'sd7) $display("FAIL add_pos out=%b expected=000111", out); else passes++;
    checks++; if (lat !== 1) $display("FAIL add_latency lat=%0d expected=1", lat); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL add_ready in_ready=%b expected=1", in_ready); else passes++;
    issue(3'd2, 3'b100, 3'b100, 0);
    wait_done(lat);
    checks++; if (out !== 6'b111000) $display("FAIL add_neg out=%b expected=111000", out); else passes++;
  endtask
  task automatic test_mul();
    int lat = 0, busy = 0, extra = 0;
    issue(3'd3, 3'b101, 3'd3);
    do begin
      if (!in_ready) busy++;
      if (lat == 1) begin opcode = 3'd2; a = 3'd1; b = 3'd1; in_valid = 1; end
      else in_valid = 0;
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 20);
    in_valid = 0;
    checks++; if (out !== 6'b110111) $display("FAIL mul_neg out=%b expected=110111", out); else passes++;
    checks++; if (lat !== 4) $display("FAIL mul_latency lat=%0d expected=4", lat); else passes++;
    checks++; if (busy !== 4) $display("FAIL mul_busy busy=%0d expected=4", busy); else passes++;
    repeat (3) begin
      @(posedge clk);
      #1 if (out_valid) extra++;
    end
    checks++; if (extra !== 0 || out !== 6'b110111) $display("FAIL mul_drop extra=%0d out=%b expected=0,110111", extra, out); else passes++;
    issue(3'd3, 3'b100, 3'b100);
    wait_done(lat);
    checks++; if (out !== 6'sd16) $display("FAIL mul_minmin out=%b expected=010000", out); else passes++;
  endtask
  task automatic test_invalid();
    int lat;
    issue(3'd6, 3'd1, 3'd1);
    wait_done(lat);
    checks++; if (out !== 6'd0 || leds !== 16'hFFFF) $display("FAIL inv1 out=%b leds=%h expected=0,FFFF", out, leds); else passes++;
    issue(3'd6, 3'd1, 3'd1);
    wait_done(lat);
    checks++; if (leds !== 16'h0000) $display("FAIL inv2 leds=%h expected=0000", leds); else passes++;
    issue(3'd3, 3'd1, 3'd1, 0, 0, 0, 1);
    wait_done(lat);
    checks++; if (leds !== 16'hFFFF || lat !== 1) $display("FAIL inv_red leds=%h lat=%0d expected=FFFF,1", leds, lat); else passes++;
    issue(3'd0, 3'd1, 3'd2);
    wait_done(lat);
    checks++; if (leds !== 16'h0000 || out !== 6'sd3) $display("FAIL or_clear leds=%h out=%b expected=0000,000011", leds, out); else passes++;
    issue(3'd1, 3'b011, 3'd0, 0, 0, 0, 1);
    wait_done(lat);
    checks++; if (out !== 6'd0) $display("FAIL xor_red out=%b expected=000000", out); else passes++;
  endtask
  task automatic test_shift_chain();
    int lat;
    issue(3'd0, 3'd1, 3'd2, 0, 0, 0, 0, 0, 1);
    wait_done(lat);
    checks++; if (out !== 6'b000001) $display("FAIL byp_a out=%b expected=000001", out); else passes++;
    issue(3'd4, 3'd0, 3'd0, 0, 0, 1);
    wait_done(lat);
    checks++; if (out !== 6'b000010) $display("FAIL shl out=%b expected=000010", out); else passes++;
    issue(3'd5, 3'd0, 3'd0, 0, 0, 0);
    wait_done(lat);
    checks++; if (out !== 6'b000001) $display("FAIL ror1 out=%b expected=000001", out); else passes++;
    issue(3'd5, 3'd0, 3'd0, 0, 0, 0);
    wait_done(lat);
    checks++; if (out !== 6'b100000) $display("FAIL ror2 out=%b expected=100000", out); else passes++;
  endtask
  task automatic test_reset_mid_mul();
    int lat, pulses = 0;
    issue(3'd7, 3'd0, 3'd0);
    wait_done(lat);
    checks++; if (leds !== 16'hFFFF) $display("FAIL pre_rst leds=%h expected=FFFF", leds); else passes++;
    issue(3'd3, 3'd3, 3'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    checks++; if ({out, out_valid, leds, in_ready} !== 24'd0) $display("FAIL mid_rst out=%b ov=%b leds=%h rdy=%b expected all 0", out, out_valid, leds, in_ready); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL rst_no_valid pulses=%0d expected=0", pulses); else passes++;
    issue(3'd2, 3'd1, 3'd2);
    wait_done(lat);
    checks++; if (out !== 6'sd3 || lat !== 1) $display("FAIL post_rst out=%b lat=%0d expected=000011,1", out, lat); else passes++;
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk);
    opcode = 3'd4; serial_in = 1; direction = 1; bypass_A = 0; bypass_B = 0; red_op_A = 0; red_op_B = 0;
    in_valid = 1;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) pulses++;
    end
    in_valid = 0;
    checks++; if (pulses !== 4) $display("FAIL b2b_pulses pulses=%0d expected=4", pulses); else passes++;
    checks++; if (out !== 6'b111111) $display("FAIL b2b_out out=%b expected=111111", out); else passes++;
  endtask
  initial begin
    test_reset();
    test_add();
    test_mul();
    test_invalid();
    test_shift_chain();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
